// File: rtl/ct_lsu_dcache_data_ctrl.sv
// Dcache data bank controller: request handshake, array pin drive,
// fixed-latency read return and zero-fill init sequencer.
module ct_lsu_dcache_data_ctrl #(
   parameter int IDX_WIDTH     = 11,
   parameter int INIT_ON_RESET = 1
) (
   input  logic                 forever_cpuclk,
   input  logic                 cpurst,
   input  logic                 req_vld,
   input  logic                 req_wr,
   input  logic [IDX_WIDTH-1:0] req_idx,
   input  logic [31:0]          req_wdata,
   input  logic [3:0]           req_be,
   output logic                 req_rdy,
   output logic                 rd_vld,
   output logic [31:0]          rd_data,
   input  logic                 init_req,
   output logic                 init_busy,
   output logic                 init_done,
   output logic                 data_sel_b,
   output logic                 data_gwen_b,
   output logic [3:0]           data_wen_b,
   output logic [IDX_WIDTH-1:0] data_idx,
   output logic [31:0]          data_din,
   output logic                 data_gateclk_en,
   input  logic [31:0]          data_dout
);

   typedef enum logic {
      S_INIT,
      S_IDLE
   } state_t;

   localparam state_t RST_STATE = (INIT_ON_RESET != 0) ? S_INIT : S_IDLE;

   state_t               state;
   logic [IDX_WIDTH-1:0] init_cnt;
   logic                 rd_pend;
   logic                 req_acc;
   logic                 rd_acc;
   logic                 wr_acc;

   assign req_rdy   = ~cpurst & (state == S_IDLE) & ~init_req;
   assign init_busy = ~cpurst & (state == S_INIT);
   assign req_acc   = req_vld & req_rdy;
   assign rd_acc    = req_acc & ~req_wr;
   // A write with no byte enables is accepted but never touches the array.
   assign wr_acc    = req_acc & req_wr & (|req_be);

   always_comb begin
      data_sel_b  = 1'b1;
      data_gwen_b = 1'b1;
      data_wen_b  = 4'hF;
      data_idx    = req_idx;
      data_din    = req_wdata;
      if (cpurst) begin
         data_idx = '0;
         data_din = '0;
      end else if (state == S_INIT) begin
         data_sel_b  = 1'b0;
         data_gwen_b = 1'b0;
         data_wen_b  = 4'h0;
         data_idx    = init_cnt;
         data_din    = '0;
      end else if (rd_acc) begin
         data_sel_b = 1'b0;
      end else if (wr_acc) begin
         data_sel_b  = 1'b0;
         data_gwen_b = 1'b0;
         data_wen_b  = ~req_be;
      end
   end

   assign data_gateclk_en = ~data_sel_b;

   always_ff @(posedge forever_cpuclk) begin
      if (cpurst) begin
         state     <= RST_STATE;
         init_cnt  <= '0;
         rd_pend   <= 1'b0;
         rd_vld    <= 1'b0;
         rd_data   <= '0;
         init_done <= 1'b0;
      end else begin
         init_done <= 1'b0;
         rd_pend   <= rd_acc;
         rd_vld    <= rd_pend;
         if (rd_pend)
            rd_data <= data_dout;
         unique case (state)
            S_INIT: begin
               init_cnt <= init_cnt + 1'b1;
               if (init_cnt == '1) begin
                  state     <= S_IDLE;
                  init_done <= 1'b1;
               end
            end
            S_IDLE: begin
               if (init_req) begin
                  state    <= S_INIT;
                  init_cnt <= '0;
               end
            end
            default: state <= RST_STATE;
         endcase
      end
   end

endmodule

// File: tb/tb_ct_lsu_dcache_data_ctrl.sv
// Directed bench for ct_lsu_dcache_data_ctrl with a small SRAM array model.
module tb_ct_lsu_dcache_data_ctrl;

   localparam int IW = 4;

   logic          clk = 1'b0;
   logic          cpurst;
   logic          req_vld;
   logic          req_wr;
   logic [IW-1:0] req_idx;
   logic [31:0]   req_wdata;
   logic [3:0]    req_be;
   logic          req_rdy;
   logic          rd_vld;
   logic [31:0]   rd_data;
   logic          init_req;
   logic          init_busy;
   logic          init_done;
   logic          data_sel_b;
   logic          data_gwen_b;
   logic [3:0]    data_wen_b;
   logic [IW-1:0] data_idx;
   logic [31:0]   data_din;
   logic          data_gateclk_en;
   logic [31:0]   data_dout;

   int checks = 0;
   int failures = 0;

   logic [31:0] mem [16];

   ct_lsu_dcache_data_ctrl #(
      .IDX_WIDTH     (IW),
      .INIT_ON_RESET (1)
   ) dut (
      .forever_cpuclk  (clk),
      .cpurst          (cpurst),
      .req_vld         (req_vld),
      .req_wr          (req_wr),
      .req_idx         (req_idx),
      .req_wdata       (req_wdata),
      .req_be          (req_be),
      .req_rdy         (req_rdy),
      .rd_vld          (rd_vld),
      .rd_data         (rd_data),
      .init_req        (init_req),
      .init_busy       (init_busy),
      .init_done       (init_done),
      .data_sel_b      (data_sel_b),
      .data_gwen_b     (data_gwen_b),
      .data_wen_b      (data_wen_b),
      .data_idx        (data_idx),
      .data_din        (data_din),
      .data_gateclk_en (data_gateclk_en),
      .data_dout       (data_dout)
   );

   always #5 clk = ~clk;

   // Single-port array: byte-masked write, registered read
   always @(posedge clk) begin
      if (!data_sel_b) begin
         if (!data_gwen_b) begin
            for (int b = 0; b < 4; b++)
               if (!data_wen_b[b])
                  mem[data_idx][8*b +: 8] <= data_din[8*b +: 8];
         end else begin
            data_dout <= mem[data_idx];
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      req_vld  = 1'b0;
      req_wr   = 1'b0;
      init_req = 1'b0;
   endtask

   task automatic do_write(input logic [IW-1:0] idx, input logic [31:0] d,
                           input logic [3:0] be);
      req_vld   = 1'b1;
      req_wr    = 1'b1;
      req_idx   = idx;
      req_wdata = d;
      req_be    = be;
      #1;
      chk("wr_rdy", 32'(req_rdy), 32'd1);
      step();
      idle_in();
   endtask

   task automatic do_read(input logic [IW-1:0] idx, input logic [31:0] exp);
      req_vld = 1'b1;
      req_wr  = 1'b0;
      req_idx = idx;
      #1;
      chk("rd_sel", {data_sel_b, data_gwen_b, data_wen_b},
          {26'd0, 1'b0, 1'b1, 4'hF});
      step();
      idle_in();
      chk("rd_vld_n1", 32'(rd_vld), 32'd0);
      step();
      chk("rd_vld_n2", 32'(rd_vld), 32'd1);
      chk("rd_data", rd_data, exp);
   endtask

   task automatic run_init(input string tag);
      for (int i = 0; i < 16; i++) begin
         chk({tag, "_idx"}, 32'(data_idx), i);
         chk({tag, "_pins"}, {data_sel_b, data_gwen_b, data_wen_b,
             init_busy, req_rdy}, {26'd0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0});
         step();
      end
      chk({tag, "_done"}, {init_done, req_rdy, init_busy},
          {29'd0, 1'b1, 1'b1, 1'b0});
   endtask

   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'hA5A5A5A5;
      data_dout = '0;
      cpurst    = 1'b1;
      idle_in();
      req_idx   = 4'd9;
      req_wdata = 32'h12345678;
      req_be    = 4'hF;
      step();
      step();
      chk("rst_pins", {data_sel_b, data_gwen_b, data_wen_b, data_gateclk_en},
          {25'd0, 1'b1, 1'b1, 4'hF, 1'b0});
      chk("rst_idx_din", {28'd0, data_idx} | data_din, 32'd0);
      chk("rst_ctl", {rd_vld, init_done, init_busy, req_rdy}, 32'd0);
      chk("rst_rdata", rd_data, 32'd0);

      cpurst = 1'b0;
      #1;
      run_init("init0");
      step();
      chk("done_pulse", 32'(init_done), 32'd0);
      do_read(4'd5, 32'h0);

      req_vld   = 1'b1;
      req_wr    = 1'b1;
      req_idx   = 4'd3;
      req_wdata = 32'hDEADBEEF;
      req_be    = 4'hF;
      #1;
      chk("wr_pins", {data_sel_b, data_gwen_b, data_wen_b, data_gateclk_en},
          {25'd0, 1'b0, 1'b0, 4'h0, 1'b1});
      chk("wr_din", data_din, 32'hDEADBEEF);
      step();
      do_read(4'd3, 32'hDEADBEEF);

      req_vld   = 1'b1;
      req_wr    = 1'b1;
      req_idx   = 4'd3;
      req_wdata = 32'h11223344;
      req_be    = 4'b0101;
      #1;
      chk("wr_be_wen", 32'(data_wen_b), 32'hA);
      step();
      idle_in();
      do_read(4'd3, 32'hDE22BE44);

      do_write(4'd1, 32'h01010101, 4'hF);
      do_write(4'd2, 32'h02020202, 4'hF);
      for (int i = 0; i < 4; i++) begin
         req_vld = (i < 3);
         req_wr  = 1'b0;
         req_idx = 4'(i);
         step();
         if (i == 0)
            chk("b2b_vld0", 32'(rd_vld), 32'd0);
         else begin
            chk("b2b_vld", 32'(rd_vld), 32'd1);
            chk("b2b_data", rd_data, {4{8'(i - 1)}});
         end
      end
      idle_in();

      req_vld   = 1'b1;
      req_wr    = 1'b1;
      req_idx   = 4'd4;
      req_wdata = 32'hFFFFFFFF;
      req_be    = 4'h0;
      #1;
      chk("be0_pins", {req_rdy, data_sel_b, data_gateclk_en},
          {29'd0, 1'b1, 1'b1, 1'b0});
      step();
      idle_in();
      do_read(4'd4, 32'h0);

      req_vld = 1'b1;
      req_wr  = 1'b0;
      req_idx = 4'd3;
      step();
      init_req = 1'b1;
      req_idx  = 4'd5;
      #1;
      chk("initreq_rdy", {req_rdy, data_sel_b}, {30'd0, 1'b0, 1'b1});
      step();
      idle_in();
      chk("inflight_vld", 32'(rd_vld), 32'd1);
      chk("inflight_data", rd_data, 32'hDE22BE44);
      run_init("init1");
      step();
      do_read(4'd3, 32'h0);

      init_req = 1'b1;
      step();
      init_req = 1'b0;
      for (int i = 0; i < 7; i++) step();
      chk("mid_idx", 32'(data_idx), 32'd7);
      cpurst = 1'b1;
      #1;
      chk("mid_rst_pins", {data_sel_b, data_wen_b, data_gateclk_en,
          init_busy, req_rdy}, {25'd0, 1'b1, 4'hF, 1'b0, 1'b0, 1'b0});
      chk("mid_rst_idx", 32'(data_idx), 32'd0);
      step();
      cpurst = 1'b0;
      #1;
      run_init("init2");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
